rv32_mt_regfile: RTL and testbench
==================================

# rv32_mt_regfile

Multi-HART, parametrised register file and program-counter store for the RV32 soft core, succeeding the single-HART RV32I register file. Holds an independent GPR set, PC and last PC per HART, with HART selection on every access, an explicit write enable, and optional write-to-read bypass. Architecturally clears all GPRs with a post-reset sweep. Sits between decode (indices and HART select) and execute/writeback (new_rd, new_pc).

## Interface
- NUM_HARTS, 1: HART count; power of two, 1 to 8. HW = max(1, clog2(NUM_HARTS)).
- REGFILE_ENTRIES, 32: GPRs per HART; 32 (RV32I) or 16 (RV32E). IW = clog2(REGFILE_ENTRIES).
- RESET_VECTOR, 32'h00000000: PC value loaded into every HART at reset.
- BYPASS, 1: 1 forwards a same-cycle write to the rs1/rs2 outputs; 0 gives no forwarding.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- hart  in  HW  selects the HART for reads, the write and the PC update in this cycle.
- rs1_idx  in  IW  source 1 index.
- rs2_idx  in  IW  source 2 index.
- rd_idx  in  IW  destination index.
- rd_we  in  1  destination write enable.
- new_rd  in  32  destination write data.
- new_pc  in  32  branch/jump base; PC becomes new_pc+4 when update_pc is high.
- update_pc  in  1  selects new_pc+4 instead of pc+4.
- stall  in  1  freezes all GPR and PC updates.
- rs1  out  32  GPR[hart][rs1_idx]; combinational.
- rs2  out  32  GPR[hart][rs2_idx]; combinational.
- pc  out  32  PC of the selected HART; combinational mux of registers.
- last_pc  out  32  previous PC of the selected HART.
- ready  out  1  high once the clear sweep completes; 0 during reset and the sweep.

## Operation
- Storage is a single array of NUM_HARTS*REGFILE_ENTRIES words, addressed {hart, idx}. Per-HART pc and last_pc registers are separate.
- FSM has two states: CLEAR and RUN.
  - reset drives CLEAR and sets clr_cnt=0.
  - In CLEAR, each cycle writes 0 to word clr_cnt and increments clr_cnt. On the final word (NUM_HARTS*REGFILE_ENTRIES-1) the FSM moves to RUN.
  - RUN is held until the next reset.
- In CLEAR, stall, update_pc and rd_we are ignored. No PC advances. Reads return array contents, which are not guaranteed to be zero.
- In RUN with stall=0:
  - last_pc[hart] <= pc[hart].
  - pc[hart] <= update_pc ? new_pc+4 : pc[hart]+4.
  - If rd_we=1 and rd_idx!=0, GPR[hart][rd_idx] <= new_rd.
  - Unselected HARTs are untouched.
- In RUN with stall=1: no state changes.
- Index 0 of every HART always reads 0. Writes to it are discarded, independent of storage contents.
- Bypass applies when BYPASS=1, in RUN, with stall=0, rd_we=1, rd_idx!=0 and rd_idx==rsN_idx. Under those conditions rsN = new_rd in the same cycle. Otherwise rsN shows stored data.
- Arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 0, and new_pc=32'hFFFFFFFC gives pc=0.
- Out-of-range hart values (NUM_HARTS not a power of two) are not supported.

## Timing
- Reset values:
  - pc[all] = RESET_VECTOR.
  - last_pc[all] = 0.
  - ready = 0.
  - State = CLEAR with clr_cnt = 0.
  - GPR contents are undefined until the sweep completes.
- Sweep length is exactly NUM_HARTS*REGFILE_ENTRIES cycles after reset deasserts. ready rises on the edge that writes the last word. ready is registered.
- Reset asserted mid-sweep or mid-run asynchronously restores all reset values. The sweep restarts from 0 after release.
- Reads are zero-latency. A write is visible through storage on the cycle after the edge, and in the same cycle only via bypass.
- The PC update is visible on pc the cycle after the edge; last_pc shows the old value in the same cycle.
- Simultaneous write and read of the same index in another HART: no bypass, and stored data is returned.

## Test plan
- NUM_HARTS=2, ENTRIES=32: assert then release reset -> ready low for 64 cycles, high at cycle 64. Every GPR reads 0. pc=RESET_VECTOR for hart 0 and hart 1.
- Hart 1, rd_we=1, rd_idx=5, new_rd=32'hDEADBEEF with rs1_idx=5 -> rs1=DEADBEEF in the same cycle (BYPASS=1). Hart 0 x5 still reads 0.
- Write x0=32'h12345678, then read rs2_idx=0 -> rs2=0. With stall=1 and rd_idx=3 -> x3 unchanged, pc and last_pc unchanged.
- Hart 0: update_pc=1, new_pc=32'h00000100 -> pc=32'h104, last_pc=RESET_VECTOR. Then new_pc=32'hFFFFFFFC -> pc=0.
- Assert reset at sweep cycle 10 after writes -> pc=RESET_VECTOR and ready=0 immediately. A full-length sweep restarts.
- BYPASS=0, ENTRIES=16: write x15 with rs1_idx=15 -> rs1 shows old value. New value appears the next cycle. Sweep takes 16*NUM_HARTS cycles.

Source files
------------

// File: rtl/rv32_mt_regfile.sv
// Multi-HART RV32 register file with per-HART PC/last-PC, post-reset clear sweep
// and optional same-cycle write-to-read forwarding.
module rv32_mt_regfile #(
  parameter int          NUM_HARTS       = 1,
  parameter int          REGFILE_ENTRIES = 32,
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter bit          BYPASS          = 1'b1,
  localparam int         HW              = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int         IW              = $clog2(REGFILE_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [HW-1:0] hart,
  input  logic [IW-1:0] rs1_idx,
  input  logic [IW-1:0] rs2_idx,
  input  logic [IW-1:0] rd_idx,
  input  logic          rd_we,
  input  logic [31:0]   new_rd,
  input  logic [31:0]   new_pc,
  input  logic          update_pc,
  input  logic          stall,
  output logic [31:0]   rs1,
  output logic [31:0]   rs2,
  output logic [31:0]   pc,
  output logic [31:0]   last_pc,
  output logic          ready
);

  localparam int DEPTH = NUM_HARTS * REGFILE_ENTRIES;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;

  logic [31:0]     mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;

  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr;
  logic [HW-1:0]   hart_sel;
  logic [31:0]     pc_bank      [NUM_HARTS];
  logic [31:0]     last_pc_bank [NUM_HARTS];

  logic            run;
  logic            advance;
  logic            rd_hit;

  assign run     = (state_reg == RUN);
  assign advance = run && !stall;
  assign rd_hit  = advance && rd_we && (rd_idx != '0);
  assign ready   = run;

  // With a single HART the select input carries no address bits.
  generate
    if (NUM_HARTS == 1) begin : g_single
      logic unused_hart;
      assign unused_hart = ^hart;
      assign hart_sel    = '0;
      assign rs1_addr    = rs1_idx;
      assign rs2_addr    = rs2_idx;
      assign rd_addr     = rd_idx;
      assign pc          = pc_bank[0];
      assign last_pc     = last_pc_bank[0];
    end else begin : g_multi
      assign hart_sel    = hart;
      assign rs1_addr    = {hart, rs1_idx};
      assign rs2_addr    = {hart, rs2_idx};
      assign rd_addr     = {hart, rd_idx};
      assign pc          = pc_bank[hart];
      assign last_pc     = last_pc_bank[hart];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      logic [31:0] pc_reg;
      logic [31:0] last_pc_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pc_reg      <= RESET_VECTOR;
          last_pc_reg <= '0;
        end else if (advance && (hart_sel == HW'(gi))) begin
          last_pc_reg <= pc_reg;
          pc_reg      <= update_pc ? (new_pc + 32'd4) : (pc_reg + 32'd4);
        end
      end

      assign pc_bank[gi]      = pc_reg;
      assign last_pc_bank[gi] = last_pc_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // The single write port is shared between the clear sweep and writeback.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    mem_we       = 1'b0;
    mem_waddr    = rd_addr;
    mem_wdata    = new_rd;
    case (state_reg)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_cnt_reg;
        mem_wdata    = '0;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == AW'(DEPTH - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (rd_hit) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rs1 = mem[rs1_addr];
    if (rs1_idx == '0) begin
      rs1 = '0;
    end else if (BYPASS && rd_hit && (rd_idx == rs1_idx)) begin
      rs1 = new_rd;
    end
  end

  always_comb begin
    rs2 = mem[rs2_addr];
    if (rs2_idx == '0) begin
      rs2 = '0;
    end else if (BYPASS && rd_hit && (rd_idx == rs2_idx)) begin
      rs2 = new_rd;
    end
  end

endmodule

// File: tb/tb_rv32_mt_regfile.sv
// Directed bench: a 2-HART/32-entry bypassing instance and a 2-HART/16-entry
// non-bypassing instance sharing clock and reset.
module tb_rv32_mt_regfile;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;

  logic [0:0]  hart;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic        rd_we, update_pc, stall;
  logic [31:0] new_rd, new_pc;
  logic [31:0] rs1, rs2, pc, last_pc;
  logic        ready;

  logic [0:0]  hart_b;
  logic [3:0]  rs1_idx_b, rs2_idx_b, rd_idx_b;
  logic        rd_we_b, update_pc_b, stall_b;
  logic [31:0] new_rd_b, new_pc_b;
  logic [31:0] rs1_b, rs2_b, pc_b, last_pc_b;
  logic        ready_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rv32_mt_regfile #(
    .NUM_HARTS(2), .REGFILE_ENTRIES(32), .RESET_VECTOR(RV), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .hart(hart),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
    .rd_we(rd_we), .new_rd(new_rd), .new_pc(new_pc),
    .update_pc(update_pc), .stall(stall),
    .rs1(rs1), .rs2(rs2), .pc(pc), .last_pc(last_pc), .ready(ready)
  );

  rv32_mt_regfile #(
    .NUM_HARTS(2), .REGFILE_ENTRIES(16), .RESET_VECTOR(RV), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .hart(hart_b),
    .rs1_idx(rs1_idx_b), .rs2_idx(rs2_idx_b), .rd_idx(rd_idx_b),
    .rd_we(rd_we_b), .new_rd(new_rd_b), .new_pc(new_pc_b),
    .update_pc(update_pc_b), .stall(stall_b),
    .rs1(rs1_b), .rs2(rs2_b), .pc(pc_b), .last_pc(last_pc_b), .ready(ready_b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rd_we = 0; update_pc = 0; stall = 1; new_rd = 0; new_pc = 0;
    rd_idx = 0; rs1_idx = 0; rs2_idx = 0; hart = 0;
    rd_we_b = 0; update_pc_b = 0; stall_b = 1; new_rd_b = 0; new_pc_b = 0;
    rd_idx_b = 0; rs1_idx_b = 0; rs2_idx_b = 0; hart_b = 0;
  endtask

  task automatic test_reset;
    int n, nb;
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    hart = 0; #1;
    tests_run++;
    if (ready !== 1'b0 || ready_b !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready: got %b/%b expected 0/0", ready, ready_b);
    end
    tests_run++;
    if (pc !== RV || last_pc !== 32'h0) begin
      tests_failed++; $display("FAIL reset_pc_h0: got pc=%h last=%h expected %h/0", pc, last_pc, RV);
    end
    hart = 1; #1;
    tests_run++;
    if (pc !== RV || last_pc !== 32'h0) begin
      tests_failed++; $display("FAIL reset_pc_h1: got pc=%h last=%h expected %h/0", pc, last_pc, RV);
    end
    @(negedge clk);
    reset = 0;
    n = 200; nb = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ready_b && nb == 0) nb = i;
      if (ready) begin n = i; break; end
    end
    tests_run++;
    if (n != 64) begin
      tests_failed++; $display("FAIL sweep_len_32: got %0d cycles expected 64", n);
    end
    tests_run++;
    if (nb != 32) begin
      tests_failed++; $display("FAIL sweep_len_16: got %0d cycles expected 32", nb);
    end
    $display("[TB] sweep: ready after %0d cycles (16-entry: %0d)", n, nb);
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 32; i++) begin
        hart = h[0:0]; rs1_idx = i[4:0]; rs2_idx = 5'(31 - i); #1;
        tests_run++;
        if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
          tests_failed++;
          $display("FAIL gpr_zero h%0d x%0d: got rs1=%h rs2=%h expected 0", h, i, rs1, rs2);
        end
      end
      for (int i = 0; i < 16; i++) begin
        hart_b = h[0:0]; rs1_idx_b = i[3:0]; #1;
        tests_run++;
        if (rs1_b !== 32'h0) begin
          tests_failed++; $display("FAIL gpr_zero_b h%0d x%0d: got %h expected 0", h, i, rs1_b);
        end
      end
      tests_run++;
      if (pc !== RV) begin
        tests_failed++; $display("FAIL post_sweep_pc h%0d: got %h expected %h", h, pc, RV);
      end
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    hart = 1; stall = 0; rd_we = 1; rd_idx = 5; new_rd = 32'hDEADBEEF; rs1_idx = 5; rs2_idx = 6;
    #1;
    tests_run++;
    if (rs1 !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL bypass_rs1: got %h expected deadbeef", rs1);
    end
    tests_run++;
    if (rs2 !== 32'h0) begin
      tests_failed++; $display("FAIL bypass_other_idx: got %h expected 0", rs2);
    end
    step();
    rd_we = 0; stall = 1;
    #1;
    tests_run++;
    if (rs1 !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL stored_h1_x5: got %h expected deadbeef", rs1);
    end
    tests_run++;
    if (pc !== RV + 32'd4 || last_pc !== RV) begin
      tests_failed++; $display("FAIL h1_pc_step: got pc=%h last=%h expected %h/%h", pc, last_pc, RV + 32'd4, RV);
    end
    hart = 0; #1;
    tests_run++;
    if (rs1 !== 32'h0) begin
      tests_failed++; $display("FAIL h0_x5_isolated: got %h expected 0", rs1);
    end
    tests_run++;
    if (pc !== RV) begin
      tests_failed++; $display("FAIL h0_pc_untouched: got %h expected %h", pc, RV);
    end
  endtask

  task automatic test_pc;
    @(negedge clk);
    hart = 0; stall = 0; rd_we = 0; update_pc = 1; new_pc = 32'h0000_0100;
    step();
    tests_run++;
    if (pc !== 32'h104 || last_pc !== RV) begin
      tests_failed++; $display("FAIL pc_jump: got pc=%h last=%h expected 00000104/%h", pc, last_pc, RV);
    end
    new_pc = 32'hFFFF_FFFC;
    step();
    tests_run++;
    if (pc !== 32'h0 || last_pc !== 32'h104) begin
      tests_failed++; $display("FAIL pc_wrap: got pc=%h last=%h expected 00000000/00000104", pc, last_pc);
    end
    update_pc = 0;
    step();
    stall = 1;
    tests_run++;
    if (pc !== 32'h4 || last_pc !== 32'h0) begin
      tests_failed++; $display("FAIL pc_seq: got pc=%h last=%h expected 00000004/00000000", pc, last_pc);
    end
    hart = 1; #1;
    tests_run++;
    if (pc !== RV + 32'd4) begin
      tests_failed++; $display("FAIL h1_pc_held: got %h expected %h", pc, RV + 32'd4);
    end
  endtask

  task automatic test_x0_and_stall;
    @(negedge clk);
    hart = 0; stall = 0; rd_we = 1; rd_idx = 0; new_rd = 32'h12345678; rs2_idx = 0;
    #1;
    tests_run++;
    if (rs2 !== 32'h0) begin
      tests_failed++; $display("FAIL x0_no_bypass: got %h expected 0", rs2);
    end
    step();
    rd_we = 0;
    tests_run++;
    if (rs2 !== 32'h0) begin
      tests_failed++; $display("FAIL x0_stored: got %h expected 0", rs2);
    end
    rd_we = 1; rd_idx = 3; new_rd = 32'hAAAA5555;
    step();
    stall = 1; rd_idx = 3; new_rd = 32'h11111111; update_pc = 1; new_pc = 32'h500; rs1_idx = 3;
    #1;
    tests_run++;
    if (rs1 !== 32'hAAAA5555) begin
      tests_failed++; $display("FAIL stall_no_bypass: got %h expected aaaa5555", rs1);
    end
    step();
    tests_run++;
    if (rs1 !== 32'hAAAA5555) begin
      tests_failed++; $display("FAIL stall_x3_held: got %h expected aaaa5555", rs1);
    end
    tests_run++;
    if (pc !== 32'hC || last_pc !== 32'h8) begin
      tests_failed++; $display("FAIL stall_pc_held: got pc=%h last=%h expected 0000000c/00000008", pc, last_pc);
    end
    rd_we = 0; update_pc = 0;
  endtask

  task automatic test_no_bypass;
    @(negedge clk);
    hart_b = 0; stall_b = 0; rd_we_b = 1; rd_idx_b = 15; new_rd_b = 32'hCAFEF00D; rs1_idx_b = 15;
    #1;
    tests_run++;
    if (rs1_b !== 32'h0) begin
      tests_failed++; $display("FAIL nobyp_old: got %h expected 0", rs1_b);
    end
    step();
    new_rd_b = 32'h0BADC0DE;
    #1;
    tests_run++;
    if (rs1_b !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL nobyp_next: got %h expected cafef00d", rs1_b);
    end
    step();
    rd_we_b = 0; stall_b = 1;
    tests_run++;
    if (rs1_b !== 32'h0BADC0DE) begin
      tests_failed++; $display("FAIL nobyp_second: got %h expected 0badc0de", rs1_b);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    reset = 1; hart = 0;
    #1;
    tests_run++;
    if (pc !== RV || last_pc !== 32'h0 || ready !== 1'b0) begin
      tests_failed++; $display("FAIL midrun_reset: got pc=%h last=%h rdy=%b expected %h/0/0", pc, last_pc, ready, RV);
    end
    @(negedge clk);
    reset = 0; stall = 0; update_pc = 1; new_pc = 32'h800; rd_we = 1; rd_idx = 7; new_rd = 32'h77;
    repeat (10) step();
    tests_run++;
    if (pc !== RV || ready !== 1'b0) begin
      tests_failed++; $display("FAIL clear_ignores_ctrl: got pc=%h rdy=%b expected %h/0", pc, ready, RV);
    end
    reset = 1;
    #1;
    tests_run++;
    if (pc !== RV || ready !== 1'b0) begin
      tests_failed++; $display("FAIL midsweep_reset: got pc=%h rdy=%b expected %h/0", pc, ready, RV);
    end
    idle_inputs();
    @(negedge clk);
    reset = 0;
    n = 200;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ready) begin n = i; break; end
    end
    tests_run++;
    if (n != 64) begin
      tests_failed++; $display("FAIL resweep_len: got %0d cycles expected 64", n);
    end
    hart = 1; rs1_idx = 5; #1;
    tests_run++;
    if (rs1 !== 32'h0) begin
      tests_failed++; $display("FAIL resweep_h1_x5: got %h expected 0", rs1);
    end
    hart = 0; rs1_idx = 3; rs2_idx = 7; #1;
    tests_run++;
    if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
      tests_failed++; $display("FAIL resweep_h0: got x3=%h x7=%h expected 0/0", rs1, rs2);
    end
  endtask

  initial begin
    test_reset();
    $display("[TB] reset/sweep done, failed so far %0d", tests_failed);
    test_bypass();
    $display("[TB] bypass done, failed so far %0d", tests_failed);
    test_pc();
    $display("[TB] pc update done, failed so far %0d", tests_failed);
    test_x0_and_stall();
    $display("[TB] x0/stall done, failed so far %0d", tests_failed);
    test_no_bypass();
    $display("[TB] no-bypass done, failed so far %0d", tests_failed);
    test_reset_mid();
    $display("[TB] mid reset done, failed so far %0d", tests_failed);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
